// File: rtl/data_mem_responder.sv
// Handshaked data-memory responder: one load/store at a time, checked for
// alignment, range and memop legality, served from a word RAM after LATENCY cycles.
module data_mem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  memop,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] memdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, next_state;
  logic [3:0]  cnt;
  logic [2:0]  op_q;
  logic        wen_q;
  logic [31:0] addr_q, data_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             is_word, is_half, is_byte;
  logic             illegal, misaligned, out_of_range, err;
  logic             access, wr_en;
  logic [3:0]       be;
  logic [31:0]      wdata, rword, load_val;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;

  // Decode of the latched request; addresses below the base wrap to a huge offset.
  assign offset       = addr_q - ADDR_BASE;
  assign idx          = offset[IDX_W+1:2];
  assign lane         = addr_q[1:0];
  assign is_word      = (op_q[1:0] == 2'b00);
  assign is_half      = (op_q[1:0] == 2'b01);
  assign is_byte      = (op_q[1:0] == 2'b10);
  assign illegal      = (op_q[1:0] == 2'b11) || (op_q == 3'b100);
  assign misaligned   = (is_half && lane[0]) || (is_word && (lane != 2'b00));
  assign out_of_range = (offset >> (IDX_W + 2)) != 32'd0;
  assign err          = illegal || misaligned || out_of_range;

  // The access always happens on the WAIT->RESP edge, so LATENCY=1 is a one-cycle WAIT
  // and resp_valid rises exactly LATENCY edges after accept.
  assign access = (state == WAIT) && (cnt == 4'd0);
  assign wr_en  = access && wen_q && !err;

  assign rword    = mem[idx];
  assign byte_sel = rword[{lane, 3'b000} +: 8];
  assign half_sel = lane[1] ? rword[31:16] : rword[15:0];

  // NOTE: every signal assigned in always_comb gets a default first so no path infers a latch.
  always_comb begin
    be       = 4'b0000;
    wdata    = data_q;
    load_val = 32'd0;
    if (is_byte) begin
      be       = 4'b0001 << lane;
      wdata    = {4{data_q[7:0]}};
      load_val = op_q[2] ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
    end else if (is_half) begin
      be       = lane[1] ? 4'b1100 : 4'b0011;
      wdata    = {2{data_q[15:0]}};
      load_val = op_q[2] ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
    end else if (is_word) begin
      be       = 4'b1111;
      load_val = rword;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid)  next_state = WAIT;
      WAIT:    if (cnt == 4'd0) next_state = RESP;
      RESP:    if (resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      op_q      <= 3'd0;
      wen_q     <= 1'b0;
      addr_q    <= 32'd0;
      data_q    <= 32'd0;
      resp_data <= 32'd0;
      resp_err  <= 1'b0;
    end else begin
      state <= next_state;
      if ((state == IDLE) && req_valid) begin
        op_q   <= memop;
        wen_q  <= mem_wen;
        addr_q <= mem_addr;
        data_q <= memdata;
        cnt    <= CNT_INIT;
      end else if ((state == WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        resp_err  <= err;
        resp_data <= (err || wen_q) ? 32'd0 : load_val;
      end
    end
  end

  // NOTE: the RAM has no reset; clearing it would turn the array into flops and it must survive rst anyway.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: instance 0 runs LATENCY=1, instance 1 runs LATENCY=3 for
// reset-during-wait and response backpressure.
module tb_data_mem_responder;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc_edge;
    int          lat;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, mem_wen, resp_ready;
  logic [2:0]  memop    [2];
  logic [31:0] mem_addr [2];
  logic [31:0] memdata  [2];
  wire  [1:0]  req_ready, resp_valid, resp_err;
  wire  [31:0] resp_data [2];

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   cyc      = 0;
  bit   seen     [2];
  int   last_hs  [2];
  int   last_acc [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.ADDR_BASE(32'h8000_0000), .DEPTH_WORDS(1024), .LATENCY(1)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .memop(memop[0]), .mem_wen(mem_wen[0]), .mem_addr(mem_addr[0]), .memdata(memdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_data(resp_data[0]), .resp_err(resp_err[0])
  );

  data_mem_responder #(.ADDR_BASE(32'h8000_0000), .DEPTH_WORDS(1024), .LATENCY(3)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .memop(memop[1]), .mem_wen(mem_wen[1]), .mem_addr(mem_addr[1]), .memdata(memdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_data(resp_data[1]), .resp_err(resp_err[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic mon(input int d);
    exp_t e;
    if (!rst) begin
      seen[d] = 1'b0;
    end else if (resp_valid[d]) begin
      if (qsize(d) == 0) begin
        if (!seen[d]) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_resp dut%0d: got resp_valid, expected none", d);
        end
        seen[d] = !resp_ready[d];
      end else begin
        e = (d == 0) ? q0[0] : q1[0];
        if (!seen[d]) begin
          seen[d] = 1'b1;
          check($sformatf("%s latency", e.name), 32'(cyc - e.acc_edge), 32'(e.lat));
        end
        if (resp_ready[d]) begin
          if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
          check($sformatf("%s data", e.name), resp_data[d], e.data);
          check($sformatf("%s err", e.name), {31'd0, resp_err[d]}, {31'd0, e.err});
          seen[d]    = 1'b0;
          last_hs[d] = cyc + 1;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic issue(input int d, input logic [2:0] op, input logic wen,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_data, input logic exp_err,
                       input bit push, input string name);
    exp_t e;
    bit   done = 1'b0;
    memop[d] = op; mem_wen[d] = wen; mem_addr[d] = addr; memdata[d] = wd;
    req_valid[d] = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (req_ready[d] && rst) begin
        done       = 1'b1;
        e.data     = exp_data;
        e.err      = exp_err;
        e.acc_edge = cyc + 1;
        e.lat      = (d == 0) ? 1 : 3;
        e.name     = name;
        if (push) begin
          if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
        last_acc[d] = cyc + 1;
      end
    end
    if (!done) begin
      n_checks++;
      n_fails++;
      $display("FAIL %s accept: got no req_ready in 100 cycles, expected accept", name);
    end
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = (qsize(d) == 0) && req_ready[d];
    end
    if (!ok) begin
      n_checks++;
      n_fails++;
      $display("FAIL drain dut%0d: got %0d pending, expected 0", d, qsize(d));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    bit any_valid;
    logic [31:0] held_data;
    logic        held_err;

    rst = 1'b0;
    req_valid = 2'b00; mem_wen = 2'b00; resp_ready = 2'b11;
    for (int d = 0; d < 2; d++) begin
      memop[d] = 3'd0; mem_addr[d] = 32'd0; memdata[d] = 32'd0;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset req_ready%0d", d),  {31'd0, req_ready[d]},  32'd1);
      check($sformatf("reset resp_valid%0d", d), {31'd0, resp_valid[d]}, 32'd0);
      check($sformatf("reset resp_data%0d", d),  resp_data[d],           32'd0);
      check($sformatf("reset resp_err%0d", d),   {31'd0, resp_err[d]},   32'd0);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // LATENCY=1: word, sub-word, byte-lane and error accesses
    issue(0, 3'b000, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1, "sw_10");
    issue(0, 3'b000, 1'b0, 32'h8000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 1, "lw_10");
    issue(0, 3'b010, 1'b0, 32'h8000_0013, 32'h0,         32'hFFFF_FFDE, 1'b0, 1, "lb_13");
    issue(0, 3'b110, 1'b0, 32'h8000_0013, 32'h0,         32'h0000_00DE, 1'b0, 1, "lbu_13");
    issue(0, 3'b001, 1'b0, 32'h8000_0010, 32'h0,         32'hFFFF_BEEF, 1'b0, 1, "lh_10");
    issue(0, 3'b101, 1'b0, 32'h8000_0012, 32'h0,         32'h0000_DEAD, 1'b0, 1, "lhu_12");
    issue(0, 3'b010, 1'b1, 32'h8000_0011, 32'h0000_0055, 32'h0000_0000, 1'b0, 1, "sb_11");
    issue(0, 3'b000, 1'b0, 32'h8000_0010, 32'h0,         32'hDEAD_55EF, 1'b0, 1, "lw_after_sb");
    issue(0, 3'b000, 1'b0, 32'h8000_0002, 32'h0,         32'h0000_0000, 1'b1, 1, "lw_misalign");
    issue(0, 3'b001, 1'b1, 32'h8000_0011, 32'h0000_9999, 32'h0000_0000, 1'b1, 1, "sh_misalign");
    issue(0, 3'b000, 1'b0, 32'h8000_0010, 32'h0,         32'hDEAD_55EF, 1'b0, 1, "lw_after_bad_sh");
    issue(0, 3'b000, 1'b0, 32'h7FFF_FFFC, 32'h0,         32'h0000_0000, 1'b1, 1, "lw_below_base");
    issue(0, 3'b000, 1'b0, 32'h8000_1000, 32'h0,         32'h0000_0000, 1'b1, 1, "lw_past_end");
    issue(0, 3'b011, 1'b0, 32'h8000_0010, 32'h0,         32'h0000_0000, 1'b1, 1, "memop_011");
    issue(0, 3'b100, 1'b1, 32'h8000_0010, 32'h1234_5678, 32'h0000_0000, 1'b1, 1, "memop_100_st");
    issue(0, 3'b001, 1'b1, 32'h8000_0012, 32'hAAAA_1234, 32'h0000_0000, 1'b0, 1, "sh_12");
    issue(0, 3'b000, 1'b0, 32'h8000_0010, 32'h0,         32'h1234_55EF, 1'b0, 1, "lw_after_sh");
    issue(0, 3'b000, 1'b1, 32'h8000_0FFC, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 1, "sw_last");
    issue(0, 3'b110, 1'b0, 32'h8000_0FFF, 32'h0,         32'h0000_00CA, 1'b0, 1, "lbu_last");
    drain(0);

    // LATENCY=3: reset during WAIT discards the pending store
    issue(1, 3'b000, 1'b1, 32'h8000_0000, 32'h2222_2222, 32'h0000_0000, 1'b0, 1, "b_sw_0");
    issue(1, 3'b000, 1'b0, 32'h8000_0000, 32'h0,         32'h2222_2222, 1'b0, 1, "b_lw_0");
    drain(1);
    issue(1, 3'b000, 1'b1, 32'h8000_0000, 32'h1111_1111, 32'h0000_0000, 1'b0, 0, "b_sw_killed");
    rst = 1'b0;
    #1;
    check("midwait req_ready",  {31'd0, req_ready[1]},  32'd1);
    check("midwait resp_valid", {31'd0, resp_valid[1]}, 32'd0);
    check("midwait resp_data",  resp_data[1],           32'd0);
    check("midwait resp_err",   {31'd0, resp_err[1]},   32'd0);
    @(negedge clk);
    rst = 1'b1;
    any_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      any_valid |= resp_valid[1];
    end
    check("midwait no response", {31'd0, any_valid}, 32'd0);
    @(posedge clk);
    #1;
    issue(1, 3'b000, 1'b0, 32'h8000_0000, 32'h0, 32'h2222_2222, 1'b0, 1, "b_lw_uncommitted");
    drain(1);

    // LATENCY=3: response held for 5 cycles while a second request waits
    resp_ready[1] = 1'b0;
    issue(1, 3'b000, 1'b0, 32'h8000_0000, 32'h0, 32'h2222_2222, 1'b0, 1, "b_lw_bp");
    fork
      issue(1, 3'b000, 1'b1, 32'h8000_0004, 32'h3333_3333, 32'h0000_0000, 1'b0, 1, "b_sw_4");
      begin
        bit got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
          @(negedge clk);
          got = resp_valid[1];
        end
        check("bp resp_valid seen", {31'd0, got}, 32'd1);
        held_data = resp_data[1];
        held_err  = resp_err[1];
        check("bp first data", held_data, 32'h2222_2222);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check($sformatf("bp data stable %0d", i),  resp_data[1],           held_data);
          check($sformatf("bp err stable %0d", i),   {31'd0, resp_err[1]},   {31'd0, held_err});
          check($sformatf("bp req_ready low %0d", i), {31'd0, req_ready[1]}, 32'd0);
        end
        @(posedge clk);
        #1 resp_ready[1] = 1'b1;
      end
    join
    check("bp accept after handshake", 32'(last_acc[1]), 32'(last_hs[1] + 1));
    issue(1, 3'b000, 1'b0, 32'h8000_0004, 32'h0, 32'h3333_3333, 1'b0, 1, "b_lw_4");
    drain(1);
    drain(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
